// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: rebuilds row/col from HSync/VSync edges, checks sync timing, locks after clean frames.
// Optional feature macro: VGA_RX_ERRCNT_EN adds a saturating err_count output.
module vga_sync_receiver #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       HSync,
  input  logic       VSync,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       pixel_valid,
  output logic       locked,
  output logic       timing_error,
`ifdef VGA_RX_ERRCNT_EN
  output logic [7:0] err_count,
`endif
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    SEARCH_H = 2'd0,
    SEARCH_V = 2'd1,
    TRACK    = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS    = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE    = 10'(H_SYNC_END);
  localparam logic [9:0] V_SS    = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE    = 10'(V_SYNC_END);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  state_t     state, state_n;
  logic       hs_d, vs_d;
  logic [3:0] count, count_n;
  logic [9:0] hnext, vnext, row_n, col_n;
  logic       hfall, vfall, exp_hs, exp_vs, h_mis, v_mis, mis, wrap;
  logic       locked_n, pv_n;

  assign hfall     = hs_d & ~HSync;
  assign vfall     = vs_d & ~VSync;
  assign state_dbg = state;

  // Position predicted for the current sample, plus the sync levels it implies.
  always_comb begin
    hnext = (row == H_LAST) ? 10'd0 : row + 10'd1;
    if (state == SEARCH_H && hfall) hnext = H_SE;
    vnext = col;
    if (hnext == 10'd0) vnext = (col == V_LAST) ? 10'd0 : col + 10'd1;
    if (state == SEARCH_V && vfall && hnext == 10'd0) vnext = V_SE;
    if (state == SEARCH_H) vnext = 10'd0;
    wrap   = (hnext == 10'd0) && (col == V_LAST);
    exp_hs = (hnext >= H_SS) && (hnext < H_SE);
    exp_vs = (vnext >= V_SS) && (vnext < V_SE);
    h_mis  = (state != SEARCH_H) && (HSync != exp_hs);
    v_mis  = (((state == TRACK) || (state == LOCKED)) && (VSync != exp_vs)) ||
             ((state == SEARCH_V) && vfall && (hnext != 10'd0));
    mis    = h_mis | v_mis;
  end

  always_comb begin
    state_n = state;
    count_n = count;
    row_n   = hnext;
    col_n   = vnext;
    if (mis) begin
      state_n = SEARCH_H;
      count_n = 4'd0;
      row_n   = 10'd0;
      col_n   = 10'd0;
    end else begin
      case (state)
        SEARCH_H: if (hfall) state_n = SEARCH_V;
        SEARCH_V: begin
          if (vfall && hnext == 10'd0) begin
            state_n = TRACK;
            count_n = 4'd0;
          end
        end
        TRACK: begin
          if (wrap) begin
            count_n = count + 4'd1;
            if (count + 4'd1 == LOCK_N) state_n = LOCKED;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Outputs derive from next-state values so pixel_valid and locked drop together.
  always_comb begin
    locked_n = (state_n == LOCKED);
    pv_n     = locked_n && (row_n < H_ACT) && (col_n < V_ACT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEARCH_H;
      count        <= 4'd0;
      hs_d         <= 1'b0;
      vs_d         <= 1'b0;
      row          <= 10'd0;
      col          <= 10'd0;
      locked       <= 1'b0;
      pixel_valid  <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      hs_d         <= HSync;
      vs_d         <= VSync;
      row          <= row_n;
      col          <= col_n;
      locked       <= locked_n;
      pixel_valid  <= pv_n;
      timing_error <= mis;
    end
  end

`ifdef VGA_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= 8'd0;
    else if (mis && err_count != 8'hff) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a scaled 20x12 raster so full frames stay short.
module tb_vga_sync_receiver;

  localparam int H_ACTIVE = 12, H_SYNC_START = 14, H_SYNC_END = 17, H_TOTAL = 20;
  localparam int V_ACTIVE = 8,  V_SYNC_START = 9,  V_SYNC_END = 11, V_TOTAL = 12;
  localparam int FRAME = H_TOTAL * V_TOTAL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       HSync = 1'b0;
  logic       VSync = 1'b0;
  logic [9:0] row, col;
  logic       pixel_valid, locked, timing_error;
  logic [1:0] state_dbg;
`ifdef VGA_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pos = 0;
  int cur_h, cur_v;

  vga_sync_receiver #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .HSync(HSync), .VSync(VSync),
    .row(row), .col(col), .pixel_valid(pixel_valid), .locked(locked),
    .timing_error(timing_error),
`ifdef VGA_RX_ERRCNT_EN
    .err_count(err_count),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Drive one raster position (optionally forcing a sync level), sample 1 ns after the edge.
  task automatic step(input int hs_f = -1, input int vs_f = -1, input bit hold = 1'b0);
    int h, v;
    h = pos % H_TOTAL;
    v = pos / H_TOTAL;
    @(negedge clk);
    HSync = (hs_f >= 0) ? (hs_f != 0) : (h >= H_SYNC_START && h < H_SYNC_END);
    VSync = (vs_f >= 0) ? (vs_f != 0) : (v >= V_SYNC_START && v < V_SYNC_END);
    @(posedge clk);
    #1;
    cur_h = h;
    cur_v = v;
    if (!hold) pos = (pos + 1) % FRAME;
  endtask

  task automatic wait_lock(input int budget, output int lock_i, output int te_cnt);
    lock_i = 0;
    te_cnt = 0;
    for (int i = 1; i <= budget && lock_i == 0; i++) begin
      step();
      if (timing_error) te_cnt++;
      if (locked) lock_i = i;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lock_i, te_cnt, e_row, e_col, e_pv, pv_cnt;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_locked", locked, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_timing_error", timing_error, 0);
`ifdef VGA_RX_ERRCNT_EN
    check("rst_err_count", err_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Test 1: ideal stream from row 0 / col 0
    pos = 0; lock_i = 0; te_cnt = 0; e_row = 0; e_col = 0;
    for (int i = 1; i <= 1000 && lock_i == 0; i++) begin
      step();
      if (i >= 18 && row != 10'(cur_h)) e_row++;
      if (i >= 221 && col != 10'(cur_v)) e_col++;
      if (timing_error) te_cnt++;
      if (locked) lock_i = i;
    end
    check("t1_lock_cycle", lock_i, 481);
    check("t1_align_row_err", e_row, 0);
    check("t1_align_col_err", e_col, 0);
    check("t1_lock_row", row, 0);
    check("t1_lock_col", col, 0);
    pv_cnt = int'(pixel_valid); e_pv = 0; e_row = 0;
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (pixel_valid) pv_cnt++;
      if (pixel_valid != (cur_h < H_ACTIVE && cur_v < V_ACTIVE)) e_pv++;
      if (row != 10'(cur_h) || col != 10'(cur_v) || !locked) e_row++;
      if (timing_error) te_cnt++;
    end
    check("t1_pv_per_frame", pv_cnt, H_ACTIVE * V_ACTIVE);
    check("t1_pv_pattern_err", e_pv, 0);
    check("t1_locked_track_err", e_row, 0);
    check("t1_no_timing_error", te_cnt, 0);

    // Test 2: stream entered mid-frame (12345 mod frame length)
    pulse_reset();
    pos = 12345 % FRAME; lock_i = 0; te_cnt = 0; e_row = -1;
    for (int i = 1; i <= 1000 && lock_i == 0; i++) begin
      step();
      if (i == 13) e_row = int'(row);
      if (timing_error) te_cnt++;
      if (locked) lock_i = i;
    end
    check("t2_first_fall_row", e_row, H_SYNC_END);
    check("t2_lock_cycle", lock_i, 376);
    check("t2_no_timing_error", te_cnt, 0);

    // Test 3: one HSync pulse a pixel short
    te_cnt = 0;
    while (pos != 2 * H_TOTAL + H_SYNC_END - 1) begin
      step();
      if (timing_error) te_cnt++;
    end
    check("t3_pre_err_quiet", te_cnt, 0);
    step(0);
    check("t3_timing_error", timing_error, 1);
    check("t3_locked_drop", locked, 0);
    check("t3_pv_drop", pixel_valid, 0);
    check("t3_row_clear", row, 0);
    step();
    check("t3_error_one_cycle", timing_error, 0);
    wait_lock(1000, lock_i, te_cnt);
    check("t3_relock_cycle", lock_i, 423);

    // Test 4: one 21-pixel line, error when HSync rises late
    te_cnt = 0;
    while (pos != 3 * H_TOTAL + H_TOTAL - 1) step();
    step(-1, -1, 1'b1);
    while (pos != 4 * H_TOTAL + H_SYNC_START - 1) begin
      step();
      if (timing_error) te_cnt++;
    end
    check("t4_pre_err_quiet", te_cnt, 0);
    step();
    check("t4_timing_error", timing_error, 1);
    check("t4_locked_drop", locked, 0);
    check("t4_col_clear", col, 0);
    wait_lock(1000, lock_i, te_cnt);
    check("t4_relock_cycle", lock_i, 387);

    // Test 5: VSync held one line too long
    while (pos != V_SYNC_END * H_TOTAL) step();
    step(-1, 1);
    check("t5_timing_error", timing_error, 1);
    check("t5_locked_drop", locked, 0);
    check("t5_row_clear", row, 0);
    while (pos != 0) step(-1, 1);
    wait_lock(3000, lock_i, te_cnt);
    check("t5_relocked", lock_i > 0, 1);

    // Test 6: asynchronous reset mid-frame while locked
    while (pos != 12345 % FRAME) step();
    check("t6_pre_pv", pixel_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_async_row", row, 0);
    check("t6_async_col", col, 0);
    check("t6_async_locked", locked, 0);
    check("t6_async_pv", pixel_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_lock(1000, lock_i, te_cnt);
    check("t6_relock_cycle", lock_i, 376);
    check("t6_no_timing_error", te_cnt, 0);

    // Error injection: 300 HSync-fall-then-bad-level sequences
    pulse_reset();
    te_cnt = 0; e_pv = 0;
    for (int i = 0; i < 300; i++) begin
      step(1, 0);
      if (timing_error) e_pv++;
      step(0, 0);
      if (timing_error) e_pv++;
      step(1, 0);
      if (timing_error) te_cnt++;
    end
    check("inj_error_pulses", te_cnt, 300);
    check("inj_stray_pulses", e_pv, 0);
`ifdef VGA_RX_ERRCNT_EN
    check("inj_err_count_sat", err_count, 255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
